// File: rtl/hex_led_pkg.sv
// Shared constants for the hex/LED bring-up block: segment table,
// decimal-point levels and the display-mode encoding.
package hex_led_pkg;

  // Display source selected by iMODE.
  typedef enum logic {
    MODE_SELFTEST = 1'b0,
    MODE_DATA     = 1'b1
  } mode_e;

  // Decimal point is active-low like the segments.
  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

  // Active-low segment patterns {g,f,e,d,c,b,a}, indexed by hex value.
  // Entry 15 is leftmost.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Pattern shown while reset is held: digit 0 with the dp dark.
  localparam logic [7:0] HEX_RESET = {DP_OFF, 7'h40};

  // The dp marks data mode so the two displays can be told apart.
  function automatic logic dp_for(input mode_e mode);
    return (mode == MODE_DATA) ? DP_ON : DP_OFF;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-low seven-segment pattern.
module seg7_decode
  import hex_led_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Straight table lookup; no state.
  always_comb begin
    seg = SEG_LUT[value];
  end

endmodule

// File: rtl/hex_led_test.sv
// Board bring-up: mirrors two data bytes onto 16 LEDs and drives one
// seven-segment digit, either stepping 0..F or rotating the data nibbles.
module hex_led_test
  import hex_led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic        iCLK_50,
  input  logic        iRST,
  input  logic        iMODE,
  input  logic [7:0]  iARR0,
  input  logic [7:0]  iARR1,
  output logic [15:0] oLEDR,
  output logic [7:0]  oHEXs
);

  localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);

  logic [25:0] presc_p0;
  logic        tick_p0;
  logic [3:0]  digit_p1;
  logic [3:0]  nibble_p1;
  logic [6:0]  seg_p1;
  mode_e       mode;

  assign mode = mode_e'(iMODE);

  // ---- stage p0: prescaler and step tick ----
  assign tick_p0 = (presc_p0 == TICK_LAST);

  // Prescaler counts 0..TICK_DIV-1 and wraps; reset restarts the full period.
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      presc_p0 <= '0;
    end else if (tick_p0) begin
      presc_p0 <= '0;
    end else begin
      presc_p0 <= presc_p0 + 26'd1;
    end
  end

  // ---- stage p1: digit counter, runs in both modes ----
  // Digit counter advances once per tick and wraps F -> 0 naturally.
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      digit_p1 <= '0;
    end else if (tick_p0) begin
      digit_p1 <= digit_p1 + 4'd1;
    end
  end

  // Pick the value to decode: the counter itself, or one data nibble
  // chosen by the low two counter bits.
  always_comb begin
    nibble_p1 = digit_p1;
    if (mode == MODE_DATA) begin
      case (digit_p1[1:0])
        2'd0:    nibble_p1 = iARR0[3:0];
        2'd1:    nibble_p1 = iARR0[7:4];
        2'd2:    nibble_p1 = iARR1[3:0];
        default: nibble_p1 = iARR1[7:4];
      endcase
    end
  end

  seg7_decode u_seg7_decode (
    .value (nibble_p1),
    .seg   (seg_p1)
  );

  // ---- stage p2: registered pin outputs ----
  // Segment register: one cycle behind the counter, mode and data.
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      oHEXs <= HEX_RESET;
    end else begin
      oHEXs <= {dp_for(mode), seg_p1};
    end
  end

  // LED register: plain one-cycle copy of the two bytes.
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      oLEDR <= '0;
    end else begin
      oLEDR <= {iARR1, iARR0};
    end
  end

endmodule

// File: tb/tb_hex_led_test.sv
// Randomized bench for hex_led_test: two instances (TICK_DIV 4 and 2) share
// stimulus and are compared each cycle against a cycle-count reference.
module tb_hex_led_test;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [7:0]  arr0, arr1;
  logic [15:0] led4, led2;
  logic [7:0]  hex4, hex2;

  always #5 clk = ~clk;

  hex_led_test #(.TICK_DIV(4)) dut4 (
    .iCLK_50(clk), .iRST(rst), .iMODE(mode), .iARR0(arr0), .iARR1(arr1),
    .oLEDR(led4), .oHEXs(hex4)
  );

  hex_led_test #(.TICK_DIV(2)) dut2 (
    .iCLK_50(clk), .iRST(rst), .iMODE(mode), .iARR0(arr0), .iARR1(arr1),
    .oLEDR(led2), .oHEXs(hex2)
  );

  // Segment patterns for values 0..F as listed for the display.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_pass   = 0;

  // Cycles since reset release for each instance, and expected outputs
  // after the coming clock edge.
  int          k4 = 0, k2 = 0;
  logic [7:0]  exp_hex4, exp_hex2;
  logic [15:0] exp_led;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Displayed pattern k cycles after reset with a step every t cycles.
  function automatic logic [7:0] ref_hex(input int k, input int t, input logic m,
                                         input logic [7:0] a0, input logic [7:0] a1);
    int d, v;
    d = (k / t) % 16;
    if (!m) v = d;
    else begin
      case (d % 4)
        0: v = a0 % 16;
        1: v = a0 / 16;
        2: v = a1 % 16;
        default: v = a1 / 16;
      endcase
    end
    return {~m, seg_tab[v]};
  endfunction

  // Advance the model using the inputs that the next edge will sample.
  task automatic model_edge();
    if (rst) begin
      k4 = 0; k2 = 0;
      exp_hex4 = 8'hC0; exp_hex2 = 8'hC0; exp_led = 16'h0000;
    end else begin
      exp_hex4 = ref_hex(k4, 4, mode, arr0, arr1);
      exp_hex2 = ref_hex(k2, 2, mode, arr0, arr1);
      exp_led  = {arr1, arr0};
      k4++; k2++;
    end
  endtask

  // One clock: model, wait for edge, check away from the edge.
  task automatic cycle();
    model_edge();
    @(negedge clk);
    check_val("hex_t4", {8'h00, hex4}, {8'h00, exp_hex4});
    check_val("hex_t2", {8'h00, hex2}, {8'h00, exp_hex2});
    check_val("led_t4", led4, exp_led);
    check_val("led_t2", led2, exp_led);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; arr0 = 8'h00; arr1 = 8'h00;
    // Reset held for a few cycles
    repeat (3) cycle();
    rst = 1'b0;

    // Self-test mode, full wrap on both instances, random data bytes
    for (int i = 0; i < 70; i++) begin
      arr0 = 8'($urandom); arr1 = 8'($urandom);
      cycle();
    end

    // LED mirror directed values
    arr0 = 8'h5A; arr1 = 8'hC3; cycle();
    arr0 = 8'h01; cycle();

    // Data mode with fixed bytes
    mode = 1'b1; arr0 = 8'h21; arr1 = 8'hE7;
    repeat (24) cycle();

    // Mid-count reset while the TICK_DIV=4 digit is 7 in self-test mode
    begin
      int guard;
      mode = 1'b0;
      guard = 0;
      while (((k4 / 4) % 16) != 7 && guard < 100) begin
        cycle();
        guard++;
      end
      check_val("find_d7", 16'(guard < 100), 16'd1);
      rst = 1'b1; cycle();
      rst = 1'b0;
      repeat (12) cycle();
    end

    // Mode toggle at digit A with iARR1=3F
    begin
      int guard;
      arr1 = 8'h3F;
      guard = 0;
      while (((k4 / 4) % 16) != 10 && guard < 100) begin
        cycle();
        guard++;
      end
      check_val("find_dA", 16'(guard < 100), 16'd1);
      mode = 1'b1;
      repeat (6) cycle();
    end

    // Random mix: data, mode flips, occasional resets
    for (int i = 0; i < 600; i++) begin
      arr0 = 8'($urandom); arr1 = 8'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
